// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE accepts, ISSUE drives the ALU, RESP holds the result.
module alu_arbiter #(
  parameter logic [4:0] IDLE_FS = 5'b00000
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        req0_valid,
  input  logic [4:0]  req0_fs,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_cin,
  output logic        req0_ready,

  input  logic        req1_valid,
  input  logic [4:0]  req1_fs,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_cin,
  output logic        req1_ready,

  output logic        rsp0_valid,
  output logic [15:0] rsp0_f,
  output logic        rsp0_cout,
  input  logic        rsp0_ready,

  output logic        rsp1_valid,
  output logic [15:0] rsp1_f,
  output logic        rsp1_cout,
  input  logic        rsp1_ready,

  output logic [4:0]  alu_fs,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  input  logic [15:0] alu_f,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_lastGrant;
  logic [4:0]  r_opFs;
  logic [15:0] r_opA;
  logic [15:0] r_opB;
  logic        r_opCin;
  logic [15:0] r_resF;
  logic        r_resCout;

  logic w_grant0;
  logic w_grant1;
  logic w_inIdle;
  logic w_inIssue;
  logic w_inResp;
  logic w_ownerReady;

  // On a tie the requester that did not win last time is granted.
  assign w_grant0 = req0_valid & (~req1_valid | r_lastGrant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);

  // Reset masks every output so nothing leaks while reset_n is held low.
  assign w_inIdle  = reset_n & (r_state == IDLE);
  assign w_inIssue = reset_n & (r_state == ISSUE);
  assign w_inResp  = reset_n & (r_state == RESP);

  assign req0_ready = w_inIdle & w_grant0;
  assign req1_ready = w_inIdle & w_grant1;

  assign w_ownerReady = r_owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_opFs      <= 5'd0;
      r_opA       <= 16'd0;
      r_opB       <= 16'd0;
      r_opCin     <= 1'b0;
      r_resF      <= 16'd0;
      r_resCout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            r_owner     <= req1_ready;
            r_lastGrant <= req1_ready;
            r_opFs      <= req1_ready ? req1_fs  : req0_fs;
            r_opA       <= req1_ready ? req1_a   : req0_a;
            r_opB       <= req1_ready ? req1_b   : req0_b;
            r_opCin     <= req1_ready ? req1_cin : req0_cin;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_resF    <= alu_f;
          r_resCout <= alu_cout;
          r_state   <= RESP;
        end
        RESP: begin
          if (w_ownerReady) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_fs  = w_inIssue ? r_opFs  : IDLE_FS;
  assign alu_a   = w_inIssue ? r_opA   : 16'd0;
  assign alu_b   = w_inIssue ? r_opB   : 16'd0;
  assign alu_cin = w_inIssue ? r_opCin : 1'b0;

  assign rsp0_valid = w_inResp & ~r_owner;
  assign rsp1_valid = w_inResp & r_owner;
  assign rsp0_f     = r_resF;
  assign rsp1_f     = r_resF;
  assign rsp0_cout  = r_resCout;
  assign rsp1_cout  = r_resCout;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model of the in-flight operation predicts
// grants, ALU drive and responses each cycle; directed scenarios run before a random phase.
module tb_alu_arbiter;

  localparam logic [4:0] TB_IDLE_FS = 5'h16;

  logic        clk;
  logic        rstN;
  logic        v0, v1, cin0, cin1, rr0, rr1;
  logic [4:0]  fs0, fs1;
  logic [15:0] a0, b0, a1, b1;
  logic        req0Ready, req1Ready;
  logic        rsp0Valid, rsp1Valid, rsp0Cout, rsp1Cout;
  logic [15:0] rsp0F, rsp1F;
  logic [4:0]  aluFs;
  logic [15:0] aluA, aluB, aluF;
  logic        aluCin, aluCout;

  int numCompared   = 0;
  int numMismatched = 0;

  // Model of the single in-flight operation: age 1 = on the ALU, age 2 = result offered.
  bit          mPending = 0;
  int          mAge     = 0;
  int          mOwner   = 0;
  int          mLast    = 1;
  logic [4:0]  mFs;
  logic [15:0] mA, mB;
  logic        mCin;
  logic [16:0] mRes;
  bit          accepted;
  int          grantLog[$];

  // Reference ALU; every FS bit influences the result so pass-through errors are visible.
  function automatic logic [16:0] aluRef(input logic [4:0] fs, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] r;
    case (fs[2:0])
      3'd0: r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      3'd1: r = {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {a, cin};
      3'd6: r = {a[0], cin, a[15:1]};
      default: r = {1'b0, ~a};
    endcase
    r[15:14] = r[15:14] ^ fs[4:3];
    r[16]    = r[16] ^ fs[4];
    return r;
  endfunction

  assign {aluCout, aluF} = aluRef(aluFs, aluA, aluB, aluCin);

  alu_arbiter #(.IDLE_FS(TB_IDLE_FS)) dut (
    .clk(clk), .reset_n(rstN),
    .req0_valid(v0), .req0_fs(fs0), .req0_a(a0), .req0_b(b0), .req0_cin(cin0), .req0_ready(req0Ready),
    .req1_valid(v1), .req1_fs(fs1), .req1_a(a1), .req1_b(b1), .req1_cin(cin1), .req1_ready(req1Ready),
    .rsp0_valid(rsp0Valid), .rsp0_f(rsp0F), .rsp0_cout(rsp0Cout), .rsp0_ready(rr0),
    .rsp1_valid(rsp1Valid), .rsp1_f(rsp1F), .rsp1_cout(rsp1Cout), .rsp1_ready(rr1),
    .alu_fs(aluFs), .alu_a(aluA), .alu_b(aluB), .alu_cin(aluCin), .alu_f(aluF), .alu_cout(aluCout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs set; checks, advances the model, returns at the next falling edge.
  task automatic stepCycle();
    int g;
    logic [1:0] expReady, expValid;
    #1;
    g = -1;
    if (v0 && v1) g = (mLast == 0) ? 1 : 0;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    expReady = 2'b00;
    if (rstN && !mPending && g >= 0) expReady = (g == 1) ? 2'b10 : 2'b01;
    checkOutput("ready", {req1Ready, req0Ready}, expReady);
    if (rstN && mPending && mAge == 1) begin
      checkOutput("aluFsCin", {aluCin, aluFs}, {mCin, mFs});
      checkOutput("aluAB", {aluA, aluB}, {mA, mB});
    end else begin
      checkOutput("aluIdleFsCin", {aluCin, aluFs}, {1'b0, TB_IDLE_FS});
      checkOutput("aluIdleAB", {aluA, aluB}, 32'd0);
    end
    expValid = 2'b00;
    if (rstN && mPending && mAge == 2) expValid = (mOwner == 1) ? 2'b10 : 2'b01;
    checkOutput("rspValid", {rsp1Valid, rsp0Valid}, expValid);
    if (expValid != 2'b00) begin
      checkOutput("rspF", (mOwner == 1) ? rsp1F : rsp0F, mRes[15:0]);
      checkOutput("rspCout", (mOwner == 1) ? rsp1Cout : rsp0Cout, mRes[16]);
    end
    @(posedge clk);
    accepted = 0;
    if (!rstN) begin
      mPending = 0;
      mLast    = 1;
    end else if (mPending) begin
      if (mAge == 2) begin
        if ((mOwner == 1) ? rr1 : rr0) mPending = 0;
      end else begin
        mAge = 2;
      end
    end else if (g >= 0) begin
      mPending = 1;
      mAge     = 1;
      mOwner   = g;
      mLast    = g;
      mFs  = (g == 1) ? fs1  : fs0;
      mA   = (g == 1) ? a1   : a0;
      mB   = (g == 1) ? b1   : b0;
      mCin = (g == 1) ? cin1 : cin0;
      mRes = aluRef(mFs, mA, mB, mCin);
      accepted = 1;
      grantLog.push_back(g);
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int who, input logic valid, input logic [4:0] fs,
                               input logic [15:0] a, input logic [15:0] b, input logic cin);
    if (who == 0) begin
      v0 = valid; fs0 = fs; a0 = a; b0 = b; cin0 = cin;
    end else begin
      v1 = valid; fs1 = fs; a1 = a; b1 = b; cin1 = cin;
    end
  endtask

  // Issue one op from a requester and wait until its response has been consumed.
  task automatic runOp(input int who, input logic [4:0] fs, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    bit done;
    done = 0;
    applyStimulus(who, 1'b1, fs, a, b, cin);
    for (int i = 0; i < 8 && !done; i++) begin
      stepCycle();
      done = accepted;
    end
    if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
    applyStimulus(who, 1'b0, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 8 && mPending; i++) stepCycle();
    if (mPending) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    rstN = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    applyStimulus(0, 1'b1, 5'h0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1, 1'b1, 5'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    $display("[TB] reset with both requesters valid");
    for (int i = 0; i < 3; i++) stepCycle();
    rstN = 1'b1;
    applyStimulus(1, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    applyStimulus(0, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    stepCycle();

    $display("[TB] single op on requester 0");
    runOp(0, 5'h02, 16'h1234, 16'h0001, 1'b0);

    $display("[TB] round-robin tie after reset");
    rstN = 1'b0;
    stepCycle();
    stepCycle();
    rstN = 1'b1;
    grantLog.delete();
    applyStimulus(0, 1'b1, 5'h00, 16'h1111, 16'h2222, 1'b0);
    applyStimulus(1, 1'b1, 5'h04, 16'h3333, 16'h0F0F, 1'b1);
    for (int i = 0; i < 12; i++) stepCycle();
    checkOutput("tieCount", (grantLog.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput("tieOrder", grantLog[i], i % 2);
    applyStimulus(0, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 6 && mPending; i++) stepCycle();

    $display("[TB] backpressure on requester 1");
    rr1 = 1'b0;
    applyStimulus(1, 1'b1, 5'h11, 16'hBEEF, 16'h1357, 1'b1);
    for (int i = 0; i < 4 && !accepted; i++) stepCycle();
    applyStimulus(1, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    applyStimulus(0, 1'b1, 5'h01, 16'h0100, 16'h0001, 1'b1);
    for (int i = 0; i < 6; i++) stepCycle();
    rr1 = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();
    applyStimulus(0, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 6 && mPending; i++) stepCycle();

    $display("[TB] FS sweep on requester 0");
    for (int f = 0; f < 32; f++) runOp(0, f[4:0], 16'hA5C3, 16'h3C5A, 1'b1);

    $display("[TB] reset during ISSUE");
    accepted = 0;
    applyStimulus(0, 1'b1, 5'h03, 16'h00FF, 16'hFF00, 1'b0);
    for (int i = 0; i < 4 && !accepted; i++) stepCycle();
    applyStimulus(0, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    rstN = 1'b0;
    stepCycle();
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();

    $display("[TB] requester 1 withdraws while requester 0 is in RESP");
    rr0 = 1'b0;
    accepted = 0;
    applyStimulus(0, 1'b1, 5'h07, 16'h4242, 16'h0000, 1'b0);
    for (int i = 0; i < 4 && !accepted; i++) stepCycle();
    applyStimulus(0, 1'b0, 5'h0, 16'h0, 16'h0, 1'b0);
    stepCycle();
    applyStimulus(1, 1'b1, 5'h09, 16'h9999, 16'h1111, 1'b1);
    stepCycle();
    applyStimulus(1, 1'b0, 5'h09, 16'h9999, 16'h1111, 1'b1);
    stepCycle();
    rr0 = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
      applyStimulus(1, $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
      rr0  = ($urandom_range(0, 3) != 0);
      rr1  = ($urandom_range(0, 3) != 0);
      rstN = ($urandom_range(0, 63) != 0);
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
